// File: rtl/pad_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pad_cfg_ctrl_if
// Brief    : valid/ready register port carrying pad config requests/responses
// Revision : 1.0
// ============================================================================
interface pad_cfg_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_commit;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [5:0]        cfg_wdata;
  logic              cfg_rvalid;
  logic [5:0]        cfg_rdata;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_commit, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_ready, cfg_rvalid, cfg_rdata, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_commit, cfg_we, cfg_addr, cfg_wdata,
    output cfg_ready, cfg_rvalid, cfg_rdata, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pad_cfg_ctrl
// Brief    : shadow/active pad configuration banks, two-phase commit, input
//            synchronisers. Optional lock register: define PAD_CFG_LOCK_EN.
// Revision : 1.0
// ============================================================================
module pad_cfg_ctrl #(
  parameter int NUM_BIDIR_PADS = 37,
  parameter int NUM_INPUT_PADS = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_W         = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pad_cfg_ctrl_if.slave             cfg,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_pad_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_core_in,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_core_out,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_core_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pad_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pad_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  input  logic [NUM_INPUT_PADS-1:0] input_pad_in,
  output logic [NUM_INPUT_PADS-1:0] input_core_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam logic [ADDR_W-1:0] c_bidir_end = ADDR_W'(NUM_BIDIR_PADS);
  localparam logic [ADDR_W-1:0] c_pad_end   = ADDR_W'(NUM_BIDIR_PADS + NUM_INPUT_PADS);

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_apply_cfg = 2'd1;
  localparam logic [1:0] c_st_apply_oe  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_ready;
  logic              w_copy_cfg;
  logic              w_copy_oe;

  logic [ADDR_W-1:0] w_addr;
  logic [5:0]        w_wdata;
  logic              w_accept;
  logic              w_is_bidir;
  logic              w_is_input;
  logic              w_is_lock;
  logic              w_locked;
  logic              w_pupd_bad;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_commit_ok;
  logic              w_req_err;
  logic              w_pad_wr;
  logic [5:0]        w_rd_data;

  logic [NUM_BIDIR_PADS-1:0] r_sh_oe, r_sh_cs, r_sh_sl, r_sh_ie, r_sh_pu, r_sh_pd;
  logic [NUM_BIDIR_PADS-1:0] r_act_oe, r_act_cs, r_act_sl, r_act_ie, r_act_pu, r_act_pd;
  logic [NUM_INPUT_PADS-1:0] r_sh_ipu, r_sh_ipd, r_act_ipu, r_act_ipd;

  logic              r_rvalid;
  logic [5:0]        r_rdata;
  logic              r_err;

  logic [SYNC_STAGES-1:0][NUM_BIDIR_PADS-1:0] r_bsync;
  logic [SYNC_STAGES-1:0][NUM_INPUT_PADS-1:0] r_isync;

  assign w_addr     = cfg.cfg_addr;
  assign w_wdata    = cfg.cfg_wdata;
  assign w_accept   = cfg.cfg_valid & w_ready;
  assign w_is_bidir = (w_addr < c_bidir_end);
  assign w_is_input = !w_is_bidir && (w_addr < c_pad_end);
  assign w_pupd_bad = w_wdata[5] & w_wdata[4];

`ifdef PAD_CFG_LOCK_EN
  logic r_lock;
  logic w_lock_set;

  assign w_is_lock  = (w_addr == '1);
  assign w_locked   = r_lock;
  assign w_lock_set = w_wr_ok & w_is_lock & w_wdata[0];

  // Sticky: only rst_n can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock <= 1'b0;
    else if (w_lock_set) r_lock <= 1'b1;
  end
`else
  assign w_is_lock = 1'b0;
  assign w_locked  = 1'b0;
`endif

  assign w_wr_ok     = w_accept & ~cfg.cfg_commit & cfg.cfg_we & ~w_locked &
                       (w_is_lock | ((w_is_bidir | w_is_input) & ~w_pupd_bad));
  assign w_rd_ok     = w_accept & ~cfg.cfg_commit & ~cfg.cfg_we &
                       (w_is_lock | w_is_bidir | w_is_input);
  assign w_commit_ok = w_accept & cfg.cfg_commit & ~w_locked;
  assign w_req_err   = w_accept & ~(w_wr_ok | w_rd_ok | w_commit_ok);
  assign w_pad_wr    = w_wr_ok & ~w_is_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_oe  <= '0;
      r_sh_cs  <= '0;
      r_sh_sl  <= '0;
      r_sh_ie  <= '1;
      r_sh_pu  <= '0;
      r_sh_pd  <= '0;
      r_sh_ipu <= '0;
      r_sh_ipd <= '0;
    end else if (w_pad_wr) begin
      for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
        if (w_addr == ADDR_W'(i)) begin
          r_sh_oe[i] <= w_wdata[0];
          r_sh_cs[i] <= w_wdata[1];
          r_sh_sl[i] <= w_wdata[2];
          r_sh_ie[i] <= w_wdata[3];
          r_sh_pu[i] <= w_wdata[4];
          r_sh_pd[i] <= w_wdata[5];
        end
      end
      // Input pads only have pull controls; other written bits are dropped.
      for (int k = 0; k < NUM_INPUT_PADS; k++) begin
        if (w_addr == ADDR_W'(NUM_BIDIR_PADS + k)) begin
          r_sh_ipu[k] <= w_wdata[4];
          r_sh_ipd[k] <= w_wdata[5];
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      if (w_addr == ADDR_W'(i))
        w_rd_data = {r_sh_pd[i], r_sh_pu[i], r_sh_ie[i], r_sh_sl[i], r_sh_cs[i], r_sh_oe[i]};
    end
    for (int k = 0; k < NUM_INPUT_PADS; k++) begin
      if (w_addr == ADDR_W'(NUM_BIDIR_PADS + k))
        w_rd_data = {r_sh_ipd[k], r_sh_ipu[k], 4'b0000};
    end
`ifdef PAD_CFG_LOCK_EN
    if (w_is_lock) w_rd_data = {5'b00000, r_lock};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      r_rdata  <= w_rd_ok ? w_rd_data : 6'd0;
      r_err    <= w_req_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:      if (w_commit_ok) w_state_nxt = c_st_apply_cfg;
      c_st_apply_cfg: w_state_nxt = c_st_apply_oe;
      c_st_apply_oe:  w_state_nxt = c_st_idle;
      default:        w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_ready    = 1'b0;
    w_copy_cfg = 1'b0;
    w_copy_oe  = 1'b0;
    case (r_state)
      c_st_idle:      w_ready    = 1'b1;
      c_st_apply_cfg: w_copy_cfg = 1'b1;
      c_st_apply_oe:  w_copy_oe  = 1'b1;
      default:        w_ready    = 1'b0;
    endcase
  end

  // Receivers and pulls settle one cycle before any driver is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_oe  <= '0;
      r_act_cs  <= '0;
      r_act_sl  <= '0;
      r_act_ie  <= '1;
      r_act_pu  <= '0;
      r_act_pd  <= '0;
      r_act_ipu <= '0;
      r_act_ipd <= '0;
    end else begin
      if (w_copy_cfg) begin
        r_act_cs  <= r_sh_cs;
        r_act_sl  <= r_sh_sl;
        r_act_ie  <= r_sh_ie;
        r_act_pu  <= r_sh_pu;
        r_act_pd  <= r_sh_pd;
        r_act_ipu <= r_sh_ipu;
        r_act_ipd <= r_sh_ipd;
      end
      if (w_copy_oe) r_act_oe <= r_sh_oe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bsync <= '0;
      r_isync <= '0;
    end else begin
      r_bsync <= {r_bsync[SYNC_STAGES-2:0], bidir_pad_in};
      r_isync <= {r_isync[SYNC_STAGES-2:0], input_pad_in};
    end
  end

  assign cfg.cfg_ready  = w_ready;
  assign cfg.cfg_rvalid = r_rvalid;
  assign cfg.cfg_rdata  = r_rdata;
  assign cfg.cfg_err    = r_err;

  assign bidir_core_in  = r_bsync[SYNC_STAGES-1];
  assign input_core_in  = r_isync[SYNC_STAGES-1];
  assign bidir_pad_out  = bidir_core_out;
  assign bidir_pad_oe   = bidir_core_oe & r_act_oe;
  assign bidir_cs       = r_act_cs;
  assign bidir_sl       = r_act_sl;
  assign bidir_ie       = r_act_ie;
  assign bidir_pu       = r_act_pu;
  assign bidir_pd       = r_act_pd;
  assign input_pu       = r_act_ipu;
  assign input_pd       = r_act_ipd;

endmodule
`default_nettype wire

// File: tb/tb_pad_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_cfg_ctrl
// Brief    : directed + randomized bench for pad_cfg_ctrl with a per-address
//            shadow/active reference model
// Revision : 1.0
// ============================================================================
module tb_pad_cfg_ctrl;
  localparam int NB = 37;
  localparam int NI = 16;
  localparam int SS = 2;
  localparam int AW = 6;
`ifdef PAD_CFG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] bidir_pad_in = '0, bidir_core_in, bidir_core_out = '0, bidir_core_oe = '0;
  logic [NB-1:0] bidir_pad_out, bidir_pad_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pad_in = '0, input_core_in, input_pu, input_pd;

  pad_cfg_ctrl_if #(.ADDR_W(AW)) cfg_if ();

  pad_cfg_ctrl #(
    .NUM_BIDIR_PADS(NB), .NUM_INPUT_PADS(NI), .SYNC_STAGES(SS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if.slave),
    .bidir_pad_in(bidir_pad_in), .bidir_core_in(bidir_core_in),
    .bidir_core_out(bidir_core_out), .bidir_core_oe(bidir_core_oe),
    .bidir_pad_out(bidir_pad_out), .bidir_pad_oe(bidir_pad_oe),
    .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
    .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_pad_in(input_pad_in), .input_core_in(input_core_in),
    .input_pu(input_pu), .input_pd(input_pd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one 6-bit word per address, {PD,PU,IE,SL,CS,OE_EN}.
  logic [5:0] m_sh [64];
  logic [5:0] m_act[64];
  bit         m_lock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 64; a++) begin
      m_sh[a]  = (a < NB) ? 6'b001000 : 6'b000000;
      m_act[a] = m_sh[a];
    end
    m_lock = 1'b0;
  endtask

  task automatic check_pads(input string tag);
    logic [NB-1:0] e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
    logic [NI-1:0] e_ipu, e_ipd;
    for (int i = 0; i < NB; i++) begin
      e_oe[i] = m_act[i][0]; e_cs[i] = m_act[i][1]; e_sl[i] = m_act[i][2];
      e_ie[i] = m_act[i][3]; e_pu[i] = m_act[i][4]; e_pd[i] = m_act[i][5];
    end
    for (int k = 0; k < NI; k++) begin
      e_ipu[k] = m_act[NB+k][4]; e_ipd[k] = m_act[NB+k][5];
    end
    chk({tag, ".cs"},     64'(bidir_cs),      64'(e_cs));
    chk({tag, ".sl"},     64'(bidir_sl),      64'(e_sl));
    chk({tag, ".ie"},     64'(bidir_ie),      64'(e_ie));
    chk({tag, ".pu"},     64'(bidir_pu),      64'(e_pu));
    chk({tag, ".pd"},     64'(bidir_pd),      64'(e_pd));
    chk({tag, ".ipu"},    64'(input_pu),      64'(e_ipu));
    chk({tag, ".ipd"},    64'(input_pd),      64'(e_ipd));
    chk({tag, ".pad_oe"}, 64'(bidir_pad_oe),  64'(bidir_core_oe & e_oe));
    chk({tag, ".pad_out"},64'(bidir_pad_out), 64'(bidir_core_out));
  endtask

  // Called and returns at a negedge; the request is accepted at the next posedge.
  task automatic req(input bit commit, input bit we, input logic [AW-1:0] addr,
                     input logic [5:0] wd, input string tag);
    bit         exp_err = 1'b0, exp_rv = 1'b0, do_commit = 1'b0;
    logic [5:0] exp_rd = 6'd0;
    bit         is_lk = LOCK_EN && (addr == 6'd63);
    bit         inr   = (int'(addr) < NB + NI);
    chk({tag, ".ready_in"}, 64'(cfg_if.cfg_ready), 64'd1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_commit = commit;
    cfg_if.cfg_we     = we;
    cfg_if.cfg_addr   = addr;
    cfg_if.cfg_wdata  = wd;
    if (commit) begin
      if (m_lock) exp_err = 1'b1; else do_commit = 1'b1;
    end else if (we) begin
      if (m_lock) exp_err = 1'b1;
      else if (is_lk) m_lock = m_lock | wd[0];
      else if (!inr || (wd[5] && wd[4])) exp_err = 1'b1;
      else m_sh[addr] = (int'(addr) < NB) ? wd : (wd & 6'b110000);
    end else begin
      if (is_lk) begin exp_rv = 1'b1; exp_rd = {5'b0, m_lock}; end
      else if (inr) begin exp_rv = 1'b1; exp_rd = m_sh[addr]; end
      else exp_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk({tag, ".err"},    64'(cfg_if.cfg_err),    64'(exp_err));
    chk({tag, ".rvalid"}, 64'(cfg_if.cfg_rvalid), 64'(exp_rv));
    chk({tag, ".rdata"},  64'(cfg_if.cfg_rdata),  64'(exp_rd));
    if (do_commit) begin
      chk({tag, ".busy0"}, 64'(cfg_if.cfg_ready), 64'd0);
      check_pads({tag, ".e0"});
      @(posedge clk); @(negedge clk);
      for (int a = 0; a < 64; a++) m_act[a] = (m_act[a] & 6'b000001) | (m_sh[a] & 6'b111110);
      chk({tag, ".busy1"}, 64'(cfg_if.cfg_ready), 64'd0);
      chk({tag, ".err1"},  64'(cfg_if.cfg_err),   64'd0);
      check_pads({tag, ".e1"});
      @(posedge clk); @(negedge clk);
      for (int a = 0; a < 64; a++) m_act[a][0] = m_sh[a][0];
      chk({tag, ".ready2"}, 64'(cfg_if.cfg_ready), 64'd1);
      check_pads({tag, ".e2"});
    end else begin
      check_pads({tag, ".pads"});
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ready"},  64'(cfg_if.cfg_ready),  64'd1);
    chk({tag, ".rvalid"}, 64'(cfg_if.cfg_rvalid), 64'd0);
    chk({tag, ".rdata"},  64'(cfg_if.cfg_rdata),  64'd0);
    chk({tag, ".err"},    64'(cfg_if.cfg_err),    64'd0);
    chk({tag, ".bcore"},  64'(bidir_core_in),     64'd0);
    chk({tag, ".icore"},  64'(input_core_in),     64'd0);
    check_pads(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] bnew, bold;
    logic [NI-1:0] inew, iold;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_commit = 1'b0; cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_addr = '0; cfg_if.cfg_wdata = '0;
    model_reset();
    bidir_core_oe = '1;
    #12;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Write then read pad 3; drivers stay off until commit.
    req(1'b0, 1'b1, 6'd3, 6'b001001, "wr3");
    req(1'b0, 1'b0, 6'd3, 6'b000000, "rd3");
    @(posedge clk); @(negedge clk);
    chk("rd3.rv_drop", 64'(cfg_if.cfg_rvalid), 64'd0);
    req(1'b1, 1'b0, 6'd0, 6'b000000, "commit1");

    // Rejections and out-of-range.
    req(1'b0, 1'b1, 6'd5, 6'b110000, "wr5_pupd");
    req(1'b0, 1'b1, 6'd63, 6'b000010, "wr63");
    req(1'b0, 1'b0, 6'd5, 6'b000000, "rd5");
    req(1'b0, 1'b0, 6'd60, 6'b000000, "rd60");

    // Input pad 0 at address NB.
    req(1'b0, 1'b1, 6'd37, 6'b011111, "wr37");
    req(1'b0, 1'b0, 6'd37, 6'b000000, "rd37");
    req(1'b1, 1'b0, 6'd0, 6'b000000, "commit2");

    // Synchroniser latency: new value visible after the SS-th edge.
    for (int t = 0; t < 4; t++) begin
      bold = bidir_pad_in; iold = input_pad_in;
      bnew = {$urandom, $urandom}; inew = NI'($urandom);
      if (t == 0) inew[0] = ~iold[0];
      bidir_pad_in = bnew; input_pad_in = inew;
      for (int k = 1; k <= SS; k++) begin
        @(posedge clk); @(negedge clk);
        chk($sformatf("sync%0d.b%0d", t, k), 64'(bidir_core_in), 64'((k >= SS) ? bnew : bold));
        chk($sformatf("sync%0d.i%0d", t, k), 64'(input_core_in), 64'((k >= SS) ? inew : iold));
      end
    end

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [AW-1:0] a;
      logic [5:0] wd;
      bit cm, we;
      bidir_core_oe  = {$urandom, $urandom};
      bidir_core_out = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = AW'($urandom_range(0, NB + NI - 1));
      else if (sel == 7) a = 6'd63;
      else               a = AW'($urandom_range(NB + NI, 63));
      wd = 6'($urandom);
      if ($urandom_range(0, 5) == 0) wd[5:4] = 2'b11;
      cm = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 1) == 1);
      req(cm, we, a, wd, $sformatf("rnd%0d", n));
    end

    // Reset asserted between the two commit phases.
    req(1'b0, 1'b1, 6'd3, 6'b010110, "pre_rst_wr");
    req(1'b0, 1'b1, 6'd40, 6'b100000, "pre_rst_wr_in");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_commit = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_commit = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_state("midrst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req(1'b0, 1'b0, 6'd3, 6'b000000, "midrst_rd3");
    req(1'b0, 1'b0, 6'd40, 6'b000000, "midrst_rd40");

`ifdef PAD_CFG_LOCK_EN
    req(1'b0, 1'b1, 6'd63, 6'b000001, "lock_set");
    req(1'b0, 1'b0, 6'd63, 6'b000000, "lock_rd");
    req(1'b0, 1'b1, 6'd0, 6'b001011, "lock_wr0");
    req(1'b1, 1'b0, 6'd0, 6'b000000, "lock_commit");
    req(1'b0, 1'b0, 6'd0, 6'b000000, "lock_rd0");
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_state("lock_rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req(1'b0, 1'b0, 6'd63, 6'b000000, "unlock_rd");
    req(1'b0, 1'b1, 6'd0, 6'b001011, "unlock_wr0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
